// File: rtl/mptr_bank.sv
// Bank of NPTR address pointers with post-modify, upper-half load and
// optional circular (base/limit) wrapping per pointer.
module mptr_bank #(
   parameter  int WIDTH = 16,
   parameter  int OFFW  = 12,
   parameter  int NPTR  = 4,
   localparam int SELW  = (NPTR > 1) ? $clog2(NPTR) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic [SELW-1:0]  sel,
   input  logic [OFFW-1:0]  offsetin,
   input  logic             write,
   input  logic             writeu,
   input  logic             write_base,
   input  logic             write_limit,
   input  logic             write_mode,
   input  logic             read_abus,
   input  logic             read_abusplus,
   input  logic             read_dbus,
   output logic [WIDTH-1:0] abus_out,
   output logic [WIDTH-1:0] dbus_out,
   output logic             wrapped,
   output logic             sel_err
);

   localparam int HALF = WIDTH / 2;
   localparam logic [SELW:0] NPTR_L = (SELW+1)'(NPTR);

   logic [WIDTH-1:0] ptr_all_s   [NPTR];
   logic [WIDTH-1:0] base_all_s  [NPTR];
   logic [WIDTH-1:0] limit_all_s [NPTR];
   logic [NPTR-1:0]  wen_all_s;

   logic [SELW:0]    sel_ext_s;
   logic             sel_ok_s;
   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] base_sel_s;
   logic [WIDTH-1:0] limit_sel_s;
   logic             wen_sel_s;

   logic [WIDTH-1:0] s_s;
   logic             s_zero_s;
   logic             s_neg_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH:0]   sum_up_s;
   logic [WIDTH:0]   sum_dn_s;
   logic             over_s;
   logic             under_s;
   logic             inverted_s;

   logic [WIDTH-1:0] next_s;
   logic             wrap_hit_s;
   logic [WIDTH-1:0] ptr_new_s;
   logic             ptr_ld_s;
   logic             wrap_set_s;
   logic             wrapped_r;

   assign sel_ext_s = {1'b0, sel};
   assign sel_ok_s  = (sel_ext_s < NPTR_L);
   assign sel_err   = ~sel_ok_s;

   // View of the selected pointer's state; an out-of-range select reads as zero.
   always_comb begin
      p_s         = '0;
      base_sel_s  = '0;
      limit_sel_s = '0;
      wen_sel_s   = 1'b0;
      if (sel_ok_s) begin
         p_s         = ptr_all_s[sel];
         base_sel_s  = base_all_s[sel];
         limit_sel_s = limit_all_s[sel];
         wen_sel_s   = wen_all_s[sel];
      end else begin
         p_s         = '0;
         base_sel_s  = '0;
         limit_sel_s = '0;
         wen_sel_s   = 1'b0;
      end
   end

   assign s_s      = WIDTH'($signed(offsetin));
   assign s_zero_s = (offsetin == '0);
   assign s_neg_s  = offsetin[OFFW-1];
   assign sum_s    = p_s + s_s;

   // Wrap tests use one extra bit so carries and borrows past the bus width still count.
   assign sum_up_s   = {1'b0, p_s} + {1'b0, s_s};
   assign sum_dn_s   = {1'b0, p_s} + {s_s[WIDTH-1], s_s};
   assign over_s     = (sum_up_s > {1'b0, limit_sel_s});
   assign under_s    = ($signed(sum_dn_s) < $signed({1'b0, base_sel_s}));
   assign inverted_s = (base_sel_s > limit_sel_s);

   // Post-modify value with optional circular substitution.
   always_comb begin
      next_s     = sum_s;
      wrap_hit_s = 1'b0;
      if (!wen_sel_s) begin
         next_s = sum_s;
      end else if (s_zero_s) begin
         next_s = p_s;
      end else if (!s_neg_s) begin
         if (inverted_s || over_s) begin
            next_s     = base_sel_s;
            wrap_hit_s = 1'b1;
         end else begin
            next_s = sum_s;
         end
      end else begin
         if (inverted_s || under_s) begin
            next_s     = limit_sel_s;
            wrap_hit_s = 1'b1;
         end else begin
            next_s = sum_s;
         end
      end
   end

   // Prioritised pointer update for the selected entry.
   always_comb begin
      ptr_new_s  = p_s;
      ptr_ld_s   = 1'b0;
      wrap_set_s = 1'b0;
      if (!sel_ok_s) begin
         ptr_ld_s = 1'b0;
      end else if (write) begin
         ptr_new_s = din;
         ptr_ld_s  = 1'b1;
      end else if (writeu) begin
         ptr_new_s = {din[WIDTH-1:HALF], p_s[HALF-1:0]};
         ptr_ld_s  = 1'b1;
      end else if (read_abus) begin
         ptr_new_s  = next_s;
         ptr_ld_s   = 1'b1;
         wrap_set_s = wrap_hit_s;
      end else begin
         ptr_ld_s = 1'b0;
      end
   end

   // Bus drivers show pre-edge contents only.
   always_comb begin
      abus_out = '0;
      dbus_out = '0;
      if (!sel_ok_s) begin
         abus_out = '0;
      end else if (read_abus) begin
         abus_out = p_s;
      end else if (read_abusplus) begin
         abus_out = sum_s;
      end else begin
         abus_out = '0;
      end
      if (sel_ok_s && read_dbus) begin
         dbus_out = p_s;
      end else begin
         dbus_out = '0;
      end
   end

   for (genvar i = 0; i < NPTR; i++) begin : g_ptr
      localparam logic [SELW:0] IDX = (SELW+1)'(i);
      logic [WIDTH-1:0] ptr_r;
      logic [WIDTH-1:0] base_r;
      logic [WIDTH-1:0] limit_r;
      logic             wen_r;
      logic             hit_s;

      assign hit_s = sel_ok_s && (sel_ext_s == IDX);

      // Per-pointer state; only the selected entry can change.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ptr_r   <= '0;
            base_r  <= '0;
            limit_r <= '1;
            wen_r   <= 1'b0;
         end else begin
            if (hit_s && ptr_ld_s) begin
               ptr_r <= ptr_new_s;
            end
            if (hit_s && write_base) begin
               base_r <= din;
            end
            if (hit_s && write_limit) begin
               limit_r <= din;
            end
            if (hit_s && write_mode) begin
               wen_r <= din[0];
            end
         end
      end

      assign ptr_all_s[i]   = ptr_r;
      assign base_all_s[i]  = base_r;
      assign limit_all_s[i] = limit_r;
      assign wen_all_s[i]   = wen_r;
   end

   // One-cycle wrap indication.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrapped_r <= 1'b0;
      end else begin
         wrapped_r <= wrap_set_s;
      end
   end

   assign wrapped = wrapped_r;

endmodule

// File: tb/tb_mptr_bank.sv
// Self-checking bench for mptr_bank: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_mptr_bank;

   localparam int W  = 16;
   localparam int OW = 12;
   localparam int NP = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  din;
   logic [SW-1:0] sel;
   logic [OW-1:0] offsetin;
   logic          write, writeu, write_base, write_limit, write_mode;
   logic          read_abus, read_abusplus, read_dbus;
   logic [W-1:0]  abus_out, dbus_out;
   logic          wrapped, sel_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_ptr   [NP];
   logic [15:0] m_base  [NP];
   logic [15:0] m_limit [NP];
   logic        m_wen   [NP];
   logic        m_wrapped;

   mptr_bank #(.WIDTH(W), .OFFW(OW), .NPTR(NP)) dut (
      .clk(clk), .reset(reset), .din(din), .sel(sel), .offsetin(offsetin),
      .write(write), .writeu(writeu), .write_base(write_base),
      .write_limit(write_limit), .write_mode(write_mode),
      .read_abus(read_abus), .read_abusplus(read_abusplus), .read_dbus(read_dbus),
      .abus_out(abus_out), .dbus_out(dbus_out), .wrapped(wrapped), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic m_reset();
      for (int i = 0; i < NP; i++) begin
         m_ptr[i] = 16'h0000; m_base[i] = 16'h0000; m_limit[i] = 16'hFFFF; m_wen[i] = 1'b0;
      end
      m_wrapped = 1'b0;
   endtask

   function automatic logic [15:0] m_abus();
      int p = int'(m_ptr[sel]);
      int s = $signed(offsetin);
      if (read_abus) return m_ptr[sel];
      else if (read_abusplus) return 16'((p + s) & 32'hFFFF);
      else return 16'h0000;
   endfunction

   function automatic logic [15:0] m_dbus();
      return read_dbus ? m_ptr[sel] : 16'h0000;
   endfunction

   task automatic m_edge();
      int p = int'(m_ptr[sel]);
      int s = $signed(offsetin);
      int t = p + s;
      int b = int'(m_base[sel]);
      int l = int'(m_limit[sel]);
      int n;
      logic wr = 1'b0;
      if (reset) return;
      if (!m_wen[sel])  n = t;
      else if (s == 0)  n = p;
      else if (s > 0) begin
         if (b > l || t > l) begin n = b; wr = 1'b1; end else n = t;
      end else begin
         if (b > l || t < b) begin n = l; wr = 1'b1; end else n = t;
      end
      if (write)           m_ptr[sel] = din;
      else if (writeu)     m_ptr[sel] = {din[15:8], m_ptr[sel][7:0]};
      else if (read_abus)  m_ptr[sel] = 16'(n & 32'hFFFF);
      m_wrapped = (!write && !writeu && read_abus) ? wr : 1'b0;
      if (write_base)  m_base[sel]  = din;
      if (write_limit) m_limit[sel] = din;
      if (write_mode)  m_wen[sel]   = din[0];
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic idle();
      din = 16'h0000; offsetin = 12'h000;
      write = 1'b0; writeu = 1'b0; write_base = 1'b0; write_limit = 1'b0; write_mode = 1'b0;
      read_abus = 1'b0; read_abusplus = 1'b0; read_dbus = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
      idle();
   endtask

   task automatic peek(input logic [SW-1:0] idx, output logic [15:0] val);
      idle();
      sel = idx; read_dbus = 1'b1;
      #1;
      val = dbus_out;
      read_dbus = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      sel = 2'd0; read_dbus = 1'b1; reset = 1'b1;
      m_reset();
      #3;
      n_checks++; if (dbus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dbus actual=%h expected=0000", dbus_out); end
      n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped actual=%b expected=0", wrapped); end
      repeat (2) @(posedge clk);
      #2;
      n_checks++; if (abus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_abus actual=%h expected=0000", abus_out); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err actual=%b expected=0", sel_err); end
      reset = 1'b0;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic test_post_increment();
      logic [15:0] v;
      sel = 2'd0; write = 1'b1; din = 16'h0F0F; tick();
      sel = 2'd0; read_abus = 1'b1; offsetin = 12'h002; #1;
      n_checks++; if (abus_out !== 16'h0F0F) begin n_fail++; $display("FAIL inc_a0 actual=%h expected=0F0F", abus_out); end
      tick(); sel = 2'd0; read_abus = 1'b1; offsetin = 12'h002; #1;
      n_checks++; if (abus_out !== 16'h0F11) begin n_fail++; $display("FAIL inc_a1 actual=%h expected=0F11", abus_out); end
      tick(); peek(2'd0, v);
      n_checks++; if (v !== 16'h0F13) begin n_fail++; $display("FAIL inc_p1 actual=%h expected=0F13", v); end
      sel = 2'd0; read_abus = 1'b1; offsetin = 12'h004; #1;
      n_checks++; if (abus_out !== 16'h0F13) begin n_fail++; $display("FAIL inc_a2 actual=%h expected=0F13", abus_out); end
      tick(); sel = 2'd0; read_abus = 1'b1; offsetin = 12'h004; #1;
      n_checks++; if (abus_out !== 16'h0F17) begin n_fail++; $display("FAIL inc_a3 actual=%h expected=0F17", abus_out); end
      tick(); peek(2'd0, v);
      n_checks++; if (v !== 16'h0F1B) begin n_fail++; $display("FAIL inc_p2 actual=%h expected=0F1B", v); end
   endtask

   task automatic test_writeu_plus();
      logic [15:0] v;
      sel = 2'd0; writeu = 1'b1; din = 16'h0300; tick();
      peek(2'd0, v);
      n_checks++; if (v !== 16'h031B) begin n_fail++; $display("FAIL writeu actual=%h expected=031B", v); end
      sel = 2'd0; read_abusplus = 1'b1; offsetin = 12'hFFF; #1;
      n_checks++; if (abus_out !== 16'h031A) begin n_fail++; $display("FAIL abusplus actual=%h expected=031A", abus_out); end
      tick(); peek(2'd0, v);
      n_checks++; if (v !== 16'h031B) begin n_fail++; $display("FAIL abusplus_hold actual=%h expected=031B", v); end
   endtask

   task automatic test_circular();
      logic [15:0] v;
      sel = 2'd1; write_base  = 1'b1; din = 16'h1000; tick();
      sel = 2'd1; write_limit = 1'b1; din = 16'h1007; tick();
      sel = 2'd1; write_mode  = 1'b1; din = 16'h0001; tick();
      sel = 2'd1; write       = 1'b1; din = 16'h1006; tick();
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'h002; tick();
      n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse actual=%b expected=1", wrapped); end
      peek(2'd1, v);
      n_checks++; if (v !== 16'h1000) begin n_fail++; $display("FAIL wrap_up_ptr actual=%h expected=1000", v); end
      tick();
      n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_up_once actual=%b expected=0", wrapped); end
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'hFFF; tick();
      n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_pulse actual=%b expected=1", wrapped); end
      peek(2'd1, v);
      n_checks++; if (v !== 16'h1007) begin n_fail++; $display("FAIL wrap_dn_ptr actual=%h expected=1007", v); end
      // zero offset in circular mode holds the pointer
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'h000; tick(); peek(2'd1, v);
      n_checks++; if (v !== 16'h1007 || wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_zero actual=%h/%b expected=1007/0", v, wrapped); end
      // inverted window: base above limit always substitutes
      sel = 2'd1; write_base = 1'b1; din = 16'h2000; tick();
      sel = 2'd1; write = 1'b1; din = 16'h0005; tick();
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'h001; tick(); peek(2'd1, v);
      n_checks++; if (v !== 16'h2000 || wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_inverted actual=%h/%b expected=2000/1", v, wrapped); end
   endtask

   task automatic test_same_cycle_select();
      logic [15:0] v;
      sel = 2'd2; write = 1'b1; read_abus = 1'b1; din = 16'hAAAA; offsetin = 12'h004; #1;
      n_checks++; if (abus_out !== 16'h0000) begin n_fail++; $display("FAIL same_cycle_abus actual=%h expected=0000", abus_out); end
      tick(); peek(2'd2, v);
      n_checks++; if (v !== 16'hAAAA) begin n_fail++; $display("FAIL same_cycle_ptr actual=%h expected=AAAA", v); end
      sel = 2'd3; write = 1'b1; din = 16'h1234; tick();
      peek(2'd3, v);
      n_checks++; if (v !== 16'h1234) begin n_fail++; $display("FAIL sel3_ptr actual=%h expected=1234", v); end
      peek(2'd0, v);
      n_checks++; if (v !== 16'h031B) begin n_fail++; $display("FAIL hold_p0 actual=%h expected=031B", v); end
      peek(2'd1, v);
      n_checks++; if (v !== 16'h2000) begin n_fail++; $display("FAIL hold_p1 actual=%h expected=2000", v); end
      peek(2'd2, v);
      n_checks++; if (v !== 16'hAAAA) begin n_fail++; $display("FAIL hold_p2 actual=%h expected=AAAA", v); end
   endtask

   task automatic test_mid_reset();
      logic [15:0] v;
      // a wrapping read is pending when reset hits
      sel = 2'd1; write = 1'b1; din = 16'h1FFF; tick();
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'h001; tick();
      n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wrap actual=%b expected=1", wrapped); end
      sel = 2'd1; read_abus = 1'b1; offsetin = 12'h001;
      #1; reset = 1'b1; m_reset(); #1;
      n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wrapped actual=%b expected=0", wrapped); end
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
         peek(2'(i), v);
         n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_ptr%0d actual=%h expected=0000", i, v); end
      end
      #1; reset = 1'b0;
      @(posedge clk); #1; idle();
      sel = 2'd0; write = 1'b1; din = 16'h5A5A; tick(); peek(2'd0, v);
      n_checks++; if (v !== 16'h5A5A) begin n_fail++; $display("FAIL post_reset_write actual=%h expected=5A5A", v); end
   endtask

   task automatic test_random();
      logic [15:0] ea, ed;
      for (int c = 0; c < 3000; c++) begin
         int r = $urandom_range(0, 99);
         sel           = 2'($urandom_range(0, 3));
         write         = (r < 5);
         writeu        = (r >= 5 && r < 8);
         read_abus     = ($urandom_range(0, 99) < 60);
         read_abusplus = ($urandom_range(0, 1) == 1);
         read_dbus     = ($urandom_range(0, 1) == 1);
         write_base    = ($urandom_range(0, 99) < 6);
         write_limit   = ($urandom_range(0, 99) < 6);
         write_mode    = ($urandom_range(0, 99) < 6);
         if ($urandom_range(0, 3) == 0) din = 16'($urandom);
         else din = 16'(32'h1000 + $urandom_range(0, 40));
         if ($urandom_range(0, 3) == 0) offsetin = 12'($urandom);
         else offsetin = 12'($signed($urandom_range(0, 16)) - 8);
         #1;
         ea = m_abus(); ed = m_dbus();
         n_checks++; if (abus_out !== ea) begin n_fail++; $display("FAIL rnd_abus cycle=%0d actual=%h expected=%h", c, abus_out, ea); end
         n_checks++; if (dbus_out !== ed) begin n_fail++; $display("FAIL rnd_dbus cycle=%0d actual=%h expected=%h", c, dbus_out, ed); end
         n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rnd_sel_err cycle=%0d actual=%b expected=0", c, sel_err); end
         tick();
         n_checks++; if (wrapped !== m_wrapped) begin n_fail++; $display("FAIL rnd_wrapped cycle=%0d actual=%b expected=%b", c, wrapped, m_wrapped); end
      end
   endtask

   initial begin
      idle();
      sel = 2'd0;
      reset = 1'b0;
      test_reset();
      test_post_increment();
      test_writeu_plus();
      test_circular();
      test_same_cycle_select();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
